addsub_serial: RTL

- Multi-cycle, parametrised signed/unsigned adder-subtractor for the fixed-point datapath of the Mandelbrot iteration engine.
- Processes wide operands in K-bit slices, LSB slice first, over N/K cycles with a registered carry chain.
- Trades latency for a narrow carry path when N is wide.
- Adds over the combinational generation: a start/ready/done handshake, a zero flag, and optional signed saturation.

---
 rtl/addsub_serial.sv | 119 +++++++++++
 1 files changed

// File: rtl/addsub_serial.sv
// Sliced adder/subtractor: processes N-bit operands K bits per cycle, LSB slice first,
// with a registered carry between slices, plus zero flag and optional signed clamp.
module addsub_serial #(
  parameter int N = 32,
  parameter int K = 8
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Start,
  output logic         Ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Subtract,
  input  logic         Saturate,
  output logic [N-1:0] Result,
  output logic         FlagN,
  output logic         FlagZ,
  output logic         FlagC,
  output logic         FlagV,
  output logic         Done
);

  localparam int S  = N / K;
  localparam int CW = (S > 1) ? $clog2(S) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(S - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT stateReg, stateNext;

  logic [N-1:0]  aReg, bEffReg, accReg, accNext;
  logic          carryReg, satReg;
  logic [CW-1:0] sliceIdxReg;

  logic [K-1:0]  aSlice, bSlice, sliceSum;
  logic [K:0]    sliceFull;
  logic          carryOut, lastSlice, rawV;
  logic [N-1:0]  satVal, finalResult;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) stateReg <= IDLE;
    else          stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (Start) stateNext = RUN;
      RUN:     if (lastSlice) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign Ready = (stateReg == IDLE);
  assign Done  = (stateReg == DONE);

  // Current slice is selected by shifting the latched operands down.
  assign aSlice    = K'(aReg >> (int'(sliceIdxReg) * K));
  assign bSlice    = K'(bEffReg >> (int'(sliceIdxReg) * K));
  assign sliceFull = {1'b0, aSlice} + {1'b0, bSlice} + (K+1)'(carryReg);
  assign sliceSum  = sliceFull[K-1:0];
  assign carryOut  = sliceFull[K];
  assign lastSlice = (sliceIdxReg == LAST_IDX);

  genvar gi;
  generate
    for (gi = 0; gi < S; gi++) begin : gSlice
      assign accNext[gi*K +: K] = (sliceIdxReg == CW'(gi)) ? sliceSum : accReg[gi*K +: K];
    end
  endgenerate

  // Overflow uses the effective addend, so subtract is handled the same way as add.
  assign rawV        = (aReg[N-1] == bEffReg[N-1]) && (accNext[N-1] != aReg[N-1]);
  assign satVal      = aReg[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  assign finalResult = (satReg && rawV) ? satVal : accNext;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      aReg        <= '0;
      bEffReg     <= '0;
      accReg      <= '0;
      carryReg    <= 1'b0;
      satReg      <= 1'b0;
      sliceIdxReg <= '0;
      Result      <= '0;
      FlagN       <= 1'b0;
      FlagZ       <= 1'b1;
      FlagC       <= 1'b0;
      FlagV       <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (Start) begin
            aReg        <= A;
            bEffReg     <= Subtract ? ~B : B;
            carryReg    <= Subtract;
            satReg      <= Saturate;
            sliceIdxReg <= '0;
          end
        end
        RUN: begin
          accReg      <= accNext;
          carryReg    <= carryOut;
          sliceIdxReg <= sliceIdxReg + CW'(1);
          if (lastSlice) begin
            Result <= finalResult;
            FlagN  <= finalResult[N-1];
            FlagZ  <= (finalResult == '0);
            FlagC  <= carryOut;
            FlagV  <= rawV;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
